// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, 8N1 framing (8E1 when UART_RX_PARITY_EN
// is defined), LSB first. The received character is presented on a valid/ready
// holding register. Framing, overrun and parity errors are reported as 1-cycle pulses.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state and o_parity_err).
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 o_parity_err
`endif
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic                 rx_meta, rx_s;
  state_t               state, state_d;
  logic [TW-1:0]        tick_cnt, tick_d;
  logic [BW-1:0]        bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  // Cleared by a frame error so a held-low (break) line does not retrigger START.
  logic                 armed, armed_d;
  logic                 stop_good, frame_bad;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_d;
  logic                 par_bad;
`endif

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM and datapath state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      armed    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      tick_cnt <= tick_d;
      bit_cnt  <= bit_d;
      shift    <= shift_d;
      armed    <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_bit  <= par_d;
`endif
    end
  end

  // Next-state logic: deframing, counters and stop-bit verdict.
  always_comb begin
    state_d   = state;
    tick_d    = tick_cnt;
    bit_d     = bit_cnt;
    shift_d   = shift;
    armed_d   = armed | rx_s;
    stop_good = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_bit;
    par_bad   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rx_s && armed) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (i_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d = S_DATA;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s, shift[DATA_BITS-1:1]};
            bit_d   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_d  = '0;
            par_d   = rx_s;
            state_d = S_STOP;
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_d  = '0;
            state_d = S_IDLE;
            if (rx_s) begin
`ifdef UART_RX_PARITY_EN
              if (^{shift, par_bit}) par_bad = 1'b1;
              else                   stop_good = 1'b1;
`else
              stop_good = 1'b1;
`endif
            end else begin
              frame_bad = 1'b1;
              armed_d   = 1'b0;
            end
          end else begin
            tick_d = tick_cnt + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: commit, accept, overrun and error pulses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_frame_err  <= frame_bad;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= par_bad;
`endif
      if (stop_good) begin
        if (!o_valid || i_ready) begin
          o_data  <= shift;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus a randomized run
// checked against a frame-level model of the receiver's holding register.
`timescale 1ns/1ps
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, fe, ov, busy;
`ifdef UART_RX_PARITY_EN
  logic       pe;
`endif
  int         tick_div = 26;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_tick      (tick),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_frame_err (fe),
    .o_overrun   (ov),
    .o_busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(pe)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (tick_div - 1) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  // Output monitor: counts events seen on the DUT outputs.
  int   n_vrise = 0, n_vcyc = 0, n_fe = 0, n_ov = 0, n_pe = 0, n_bad = 0;
  logic prev_v = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
  logic [7:0] q_got[$];
  always @(negedge clk) begin
    if (valid && !prev_v) begin
      n_vrise++;
      q_got.push_back(data);
    end
    if (valid) n_vcyc++;
    if (fe) n_fe++;
    if (ov) n_ov++;
`ifdef UART_RX_PARITY_EN
    if (pe) n_pe++;
`endif
    if ((fe && prev_fe) || (ov && prev_ov)) n_bad++;
    if ((fe || ov) && valid && !prev_v) n_bad++;
    prev_v  = valid;
    prev_fe = fe;
    prev_ov = ov;
  end

  // Reference model: holding-register occupancy and expected event counts.
  logic       m_full = 1'b0;
  int         exp_fe = 0, exp_ov = 0, exp_pe = 0;
  logic [7:0] exp_q[$];

  function automatic void model_frame(input logic [7:0] d, input logic stop_b,
                                      input logic par_ok);
    if (!stop_b) exp_fe++;
    else if (!par_ok) exp_pe++;
    else if (!m_full || ready) begin
      exp_q.push_back(d);
      m_full = 1'b1;
    end else exp_ov++;
    if (ready) m_full = 1'b0;
  endfunction

  function automatic logic [FLEN-1:0] frame(input logic [7:0] d, input logic stop_b);
`ifdef UART_RX_PARITY_EN
    return {stop_b, ^d, d, 1'b0};
`else
    return {stop_b, d, 1'b0};
`endif
  endfunction

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic set_rx(input logic b);
    @(negedge clk);
    rx = b;
  endtask

  task automatic send_bits(input logic [FLEN-1:0] bits);
    for (int i = 0; i < FLEN; i++) begin
      set_rx(bits[i]);
      wait_ticks(16);
    end
    set_rx(1'b1);
    wait_ticks(2);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (fe !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", fe); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_ov got %b exp 0", ov); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b0;
    wait_ticks(2);
  endtask

  task automatic test_basic;
    int v0, c0, f0, o0;
    ready = 1'b1;
    q_got.delete();
    v0 = n_vrise; c0 = n_vcyc; f0 = n_fe; o0 = n_ov;
    send_bits(frame(8'hA5, 1'b1));
    checks++; if (n_vrise - v0 !== 1) begin errors++; $display("FAIL basic_count got %0d exp 1", n_vrise - v0); end
    checks++; if (q_got.size() > 0 && q_got[0] !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", q_got[0]); end
    checks++; if (n_vcyc - c0 !== 1) begin errors++; $display("FAIL basic_valid_cycles got %0d exp 1", n_vcyc - c0); end
    checks++; if ((n_fe - f0) + (n_ov - o0) !== 0) begin errors++; $display("FAIL basic_err_pulses got %0d exp 0", (n_fe - f0) + (n_ov - o0)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", busy); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = n_vrise; f0 = n_fe;
    set_rx(1'b0);
    wait_ticks(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got %b exp 1", busy); end
    wait_ticks(2);
    set_rx(1'b1);
    wait_ticks(8);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b exp 0", busy); end
    checks++; if (n_vrise - v0 !== 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", n_vrise - v0); end
    checks++; if (n_fe - f0 !== 0) begin errors++; $display("FAIL glitch_fe got %0d exp 0", n_fe - f0); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = n_vrise; f0 = n_fe;
    send_bits(frame(8'h3C, 1'b0));
    checks++; if (n_fe - f0 !== 1) begin errors++; $display("FAIL frame_err_pulse got %0d exp 1", n_fe - f0); end
    checks++; if (n_vrise - v0 !== 0) begin errors++; $display("FAIL frame_err_valid got %0d exp 0", n_vrise - v0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL frame_err_valid_lvl got %b exp 0", valid); end
  endtask

  task automatic test_overrun;
    int v0, o0, b0;
    ready = 1'b0;
    v0 = n_vrise; o0 = n_ov; b0 = n_bad;
    send_bits(frame(8'h11, 1'b1));
    send_bits(frame(8'h22, 1'b1));
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL overrun_valid got %b exp 1", valid); end
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL overrun_data got %h exp 11", data); end
    checks++; if (n_ov - o0 !== 1) begin errors++; $display("FAIL overrun_pulse got %0d exp 1", n_ov - o0); end
    checks++; if (n_vrise - v0 !== 1) begin errors++; $display("FAIL overrun_vrise got %0d exp 1", n_vrise - v0); end
    checks++; if (n_bad - b0 !== 0) begin errors++; $display("FAIL overrun_pulse_shape got %0d exp 0", n_bad - b0); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL accept_valid got %b exp 0", valid); end
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL accept_data_hold got %h exp 11", data); end
  endtask

  task automatic test_reset_mid;
    logic [FLEN-1:0] bits;
    ready = 1'b1;
    q_got.delete();
    bits = frame(8'h5A, 1'b1);
    for (int i = 0; i < 5; i++) begin
      set_rx(bits[i]);
      wait_ticks(16);
    end
    set_rx(bits[5]);
    wait_ticks(8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", data); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", valid); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(2);
    send_bits(frame(8'h7E, 1'b1));
    checks++; if (q_got.size() !== 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", q_got.size()); end
    checks++; if (q_got.size() > 0 && q_got[q_got.size()-1] !== 8'h7E) begin errors++; $display("FAIL rstmid_next got %h exp 7e", q_got[q_got.size()-1]); end
  endtask

  task automatic test_break;
    int v0, f0;
    logic [7:0] d;
    tick_div = 6;
    v0 = n_vrise; f0 = n_fe;
    q_got.delete();
    set_rx(1'b0);
    wait_ticks(16 * 14);
    checks++; if (n_fe - f0 !== 1) begin errors++; $display("FAIL break_fe got %0d exp 1", n_fe - f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b exp 0", busy); end
    checks++; if (n_vrise - v0 !== 0) begin errors++; $display("FAIL break_valid got %0d exp 0", n_vrise - v0); end
    set_rx(1'b1);
    wait_ticks(4);
    d = 8'($urandom);
    send_bits(frame(d, 1'b1));
    checks++; if (q_got.size() !== 1 || q_got[0] !== d) begin errors++; $display("FAIL break_recover got %0d bytes exp 1 byte %h", q_got.size(), d); end
  endtask

  task automatic test_random;
    int f0, o0, b0;
    logic [7:0] d;
    logic       sb;
    tick_div = 6;
    ready = 1'b1;
    wait_ticks(2);
    m_full = 1'b0;
    exp_fe = 0; exp_ov = 0; exp_pe = 0;
    exp_q.delete();
    q_got.delete();
    f0 = n_fe; o0 = n_ov; b0 = n_bad;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ready = 1'($urandom_range(0, 1));
      if (ready) m_full = 1'b0;
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send_bits(frame(d, sb));
      model_frame(d, sb, 1'b1);
    end
    checks++; if (n_fe - f0 !== exp_fe) begin errors++; $display("FAIL rand_fe got %0d exp %0d", n_fe - f0, exp_fe); end
    checks++; if (n_ov - o0 !== exp_ov) begin errors++; $display("FAIL rand_ov got %0d exp %0d", n_ov - o0, exp_ov); end
    checks++; if (n_bad - b0 !== 0) begin errors++; $display("FAIL rand_pulse_shape got %0d exp 0", n_bad - b0); end
    checks++; if (q_got.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", q_got.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < q_got.size(); k++) begin
      checks++;
      if (q_got[k] !== exp_q[k]) begin errors++; $display("FAIL rand_data[%0d] got %h exp %h", k, q_got[k], exp_q[k]); end
    end
    ready = 1'b1;
    wait_ticks(2);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    tick_div = 26;
    ready = 1'b1;
    q_got.delete();
    v0 = n_vrise; p0 = n_pe;
    send_bits({1'b1, 1'b0, 8'h07, 1'b0});
    checks++; if (n_pe - p0 !== 1) begin errors++; $display("FAIL parity_err_pulse got %0d exp 1", n_pe - p0); end
    checks++; if (n_vrise - v0 !== 0) begin errors++; $display("FAIL parity_err_valid got %0d exp 0", n_vrise - v0); end
    send_bits({1'b1, 1'b1, 8'h07, 1'b0});
    checks++; if (n_pe - p0 !== 1) begin errors++; $display("FAIL parity_ok_pulse got %0d exp 1", n_pe - p0); end
    checks++; if (q_got.size() !== 1 || q_got[0] !== 8'h07) begin errors++; $display("FAIL parity_ok_data got %0d bytes exp 1 byte 07", q_got.size()); end
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_break();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
